// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one single-port memory bus between instruction fetch (IF) and the
// memory-access stage (MEM). MEM has priority. A starvation counter forces IF
// through after STARVE_LIMIT MEM grants taken while IF was requesting. A
// watchdog ends a transfer that sees no slave ack within TIMEOUT cycles.
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   if_req_i/if_addr_i           IF read request and address
//   if_ack_o/if_rdata_o          IF completion pulse and read data
//   mem_req_i/mem_we_i/mem_sel_i MEM request, write enable, byte enables
//   mem_addr_i/mem_wdata_i       MEM address and write data
//   mem_ack_o/mem_rdata_o        MEM completion pulse and read data
//   bus_req_o/bus_we_o/bus_sel_o bus cycle active, write enable, byte enables
//   bus_addr_o/bus_wdata_o       bus address and write data
//   bus_ack_i/bus_rdata_i        slave completion pulse and read data
//   err_o                        pulse: watchdog terminated the transfer
//   stallreq_o                   combinational pipeline stall request

module mem_bus_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              mem_ack_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              err_o,
    output logic              stallreq_o
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned WW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IF  = 2'd1,
        GNT_MEM = 2'd2
    } state_t;

    state_t            state_q;
    logic [SW-1:0]     starve_q;
    logic [WW-1:0]     wd_q;
    logic              if_ack_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic              mem_ack_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [3:0]        bus_sel_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_q;
    logic              err_q;

    logic if_vld_c;
    logic mem_vld_c;
    logic starved_c;
    logic pick_mem_c;
    logic pick_if_c;
    logic wd_expired_c;
    logic finish_c;

    // A port acked in the previous cycle is not re-granted at this edge, so a
    // requester that drops req on seeing ack does not get a phantom transfer.
    assign if_vld_c   = if_req_i & ~if_ack_q;
    assign mem_vld_c  = mem_req_i & ~mem_ack_q;
    assign starved_c  = (starve_q >= STARVE_MAX);
    assign pick_mem_c = mem_vld_c & (~if_vld_c | ~starved_c);
    assign pick_if_c  = if_vld_c & ~pick_mem_c;

    // Slave ack on the last watchdog cycle takes precedence over the timeout.
    assign wd_expired_c = (wd_q == WD_LAST);
    assign finish_c     = bus_ack_i | wd_expired_c;

    // Arbitration, bus sequencing, watchdog and starvation tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            wd_q        <= '0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            mem_ack_q   <= 1'b0;
            mem_rdata_q <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'h0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if_ack_q  <= 1'b0;
            mem_ack_q <= 1'b0;
            err_q     <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (pick_mem_c) begin
                        state_q     <= GNT_MEM;
                        wd_q        <= '0;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mem_we_i;
                        bus_sel_q   <= mem_sel_i;
                        bus_addr_q  <= mem_addr_i;
                        bus_wdata_q <= mem_wdata_i;
                        // Count MEM wins while IF is waiting, saturating.
                        if (if_req_i && !starved_c) begin
                            starve_q <= starve_q + SW'(1);
                        end
                    end else if (pick_if_c) begin
                        state_q     <= GNT_IF;
                        wd_q        <= '0;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b0;
                        bus_sel_q   <= 4'hF;
                        bus_addr_q  <= if_addr_i;
                        bus_wdata_q <= '0;
                        starve_q    <= '0;
                    end
                end

                GNT_IF: begin
                    if (finish_c) begin
                        state_q    <= IDLE;
                        bus_req_q  <= 1'b0;
                        bus_we_q   <= 1'b0;
                        bus_sel_q  <= 4'h0;
                        if_ack_q   <= 1'b1;
                        err_q      <= ~bus_ack_i;
                        if_rdata_q <= bus_ack_i ? bus_rdata_i : '0;
                    end else begin
                        wd_q <= wd_q + WW'(1);
                    end
                end

                GNT_MEM: begin
                    if (finish_c) begin
                        state_q   <= IDLE;
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        bus_sel_q <= 4'h0;
                        mem_ack_q <= 1'b1;
                        err_q     <= ~bus_ack_i;
                        // Writes keep the previous read data; aborts return zero.
                        if (!bus_ack_i) begin
                            mem_rdata_q <= '0;
                        end else if (!bus_we_q) begin
                            mem_rdata_q <= bus_rdata_i;
                        end
                    end else begin
                        wd_q <= wd_q + WW'(1);
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    bus_req_q <= 1'b0;
                    bus_we_q  <= 1'b0;
                    bus_sel_q <= 4'h0;
                end
            endcase
        end
    end

    assign if_ack_o    = if_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign mem_ack_o   = mem_ack_q;
    assign mem_rdata_o = mem_rdata_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_sel_o   = bus_sel_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign err_o       = err_q;

    // Stall while any requester is still waiting for its completion pulse.
    assign stallreq_o = (mem_req_i & ~mem_ack_q) | (if_req_i & ~if_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by a
// randomized run compared cycle by cycle against a transaction-level model.

module tb_mem_bus_arbiter;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned TIMEOUT      = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              mem_req_i;
    logic              mem_we_i;
    logic [3:0]        mem_sel_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic              mem_ack_o;
    logic [DATA_W-1:0] mem_rdata_o;
    logic              bus_req_o;
    logic              bus_we_o;
    logic [3:0]        bus_sel_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic              bus_ack_i;
    logic [DATA_W-1:0] bus_rdata_i;
    logic              err_o;
    logic              stallreq_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_ack_o(mem_ack_o), .mem_rdata_o(mem_rdata_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .err_o(err_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        mem_req_i   = 1'b0;
        mem_we_i    = 1'b0;
        mem_sel_i   = 4'h0;
        mem_addr_i  = '0;
        mem_wdata_i = '0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
    endtask

    // ---------------- reference model (transaction level) ----------------
    // owner: 0 none, 1 IF, 2 MEM; age: edges elapsed since the grant.
    int          m_owner;
    int          m_age;
    int          m_starve;
    bit          m_if_ack, m_mem_ack, m_err, m_bus_req, m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_addr, m_wdata, m_if_rd, m_mem_rd;

    task automatic model_reset();
        m_owner = 0; m_age = 0; m_starve = 0;
        m_if_ack = 0; m_mem_ack = 0; m_err = 0; m_bus_req = 0; m_we = 0;
        m_sel = 4'h0; m_addr = '0; m_wdata = '0; m_if_rd = '0; m_mem_rd = '0;
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_step();
        bit blocked_if, blocked_mem, want_if, want_mem;
        blocked_if  = m_if_ack;
        blocked_mem = m_mem_ack;
        m_if_ack = 0; m_mem_ack = 0; m_err = 0;
        if (m_owner == 0) begin
            want_if  = if_req_i && !blocked_if;
            want_mem = mem_req_i && !blocked_mem;
            if (want_mem && (!want_if || m_starve < int'(STARVE_LIMIT))) begin
                if (if_req_i && m_starve < int'(STARVE_LIMIT)) m_starve++;
                m_owner = 2; m_age = 0; m_bus_req = 1;
                m_we = mem_we_i; m_sel = mem_sel_i; m_addr = mem_addr_i; m_wdata = mem_wdata_i;
            end else if (want_if) begin
                m_starve = 0;
                m_owner = 1; m_age = 0; m_bus_req = 1;
                m_we = 0; m_sel = 4'hF; m_addr = if_addr_i; m_wdata = '0;
            end
        end else begin
            m_age++;
            if (bus_ack_i || m_age == int'(TIMEOUT)) begin
                if (m_owner == 1) begin
                    m_if_ack = 1;
                    m_if_rd  = bus_ack_i ? bus_rdata_i : 32'h0;
                end else begin
                    m_mem_ack = 1;
                    if (!bus_ack_i) m_mem_rd = 32'h0;
                    else if (!m_we) m_mem_rd = bus_rdata_i;
                end
                m_err = !bus_ack_i;
                m_owner = 0; m_bus_req = 0; m_we = 0; m_sel = 4'h0;
            end
        end
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        n_checks++; if ({if_ack_o, mem_ack_o, err_o, bus_req_o, bus_we_o} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {if_ack_o, mem_ack_o, err_o, bus_req_o, bus_we_o}); end
        n_checks++; if (bus_sel_o !== 4'h0) begin n_fail++; $display("FAIL reset_sel: got %h want 0", bus_sel_o); end
        n_checks++; if (bus_addr_o !== 32'h0 || bus_wdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_bus: got addr %h wdata %h want 0", bus_addr_o, bus_wdata_o); end
        n_checks++; if (if_rdata_o !== 32'h0 || mem_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0", if_rdata_o, mem_rdata_o); end
        n_checks++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stallreq_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_if_read();
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        tick();
        n_checks++; if (bus_req_o !== 1'b1 || bus_we_o !== 1'b0) begin n_fail++; $display("FAIL if_read_grant: got req %b we %b want 1 0", bus_req_o, bus_we_o); end
        n_checks++; if (bus_sel_o !== 4'hF) begin n_fail++; $display("FAIL if_read_sel: got %h want f", bus_sel_o); end
        n_checks++; if (bus_addr_o !== 32'h100) begin n_fail++; $display("FAIL if_read_addr: got %h want 100", bus_addr_o); end
        n_checks++; if (if_ack_o !== 1'b0) begin n_fail++; $display("FAIL if_read_early_ack: got %b want 0", if_ack_o); end
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hDEADBEEF;
        tick();
        n_checks++; if (if_ack_o !== 1'b1 || err_o !== 1'b0) begin n_fail++; $display("FAIL if_read_ack: got ack %b err %b want 1 0", if_ack_o, err_o); end
        n_checks++; if (if_rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL if_read_data: got %h want deadbeef", if_rdata_o); end
        n_checks++; if (bus_req_o !== 1'b0 || bus_sel_o !== 4'h0) begin n_fail++; $display("FAIL if_read_release: got req %b sel %h want 0 0", bus_req_o, bus_sel_o); end
        n_checks++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL if_read_stall: got %b want 0", stallreq_o); end
        if_req_i  = 1'b0;
        bus_ack_i = 1'b0;
        tick();
        n_checks++; if (if_ack_o !== 1'b0 || bus_req_o !== 1'b0) begin n_fail++; $display("FAIL if_read_pulse: got ack %b req %b want 0 0", if_ack_o, bus_req_o); end
    endtask

    task automatic test_back_to_back();
        if_req_i  = 1'b1;
        if_addr_i = 32'h104;
        tick();
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h11111111;
        tick();
        n_checks++; if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h11111111) begin n_fail++; $display("FAIL b2b_first: got ack %b data %h want 1 11111111", if_ack_o, if_rdata_o); end
        if_addr_i = 32'h108;
        bus_ack_i = 1'b0;
        tick();
        n_checks++; if (bus_req_o !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got req %b want 0", bus_req_o); end
        tick();
        n_checks++; if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h108) begin n_fail++; $display("FAIL b2b_second: got req %b addr %h want 1 108", bus_req_o, bus_addr_o); end
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h22222222;
        tick();
        n_checks++; if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h22222222) begin n_fail++; $display("FAIL b2b_second_data: got ack %b data %h want 1 22222222", if_ack_o, if_rdata_o); end
        if_req_i  = 1'b0;
        bus_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        if_req_i    = 1'b1;
        if_addr_i   = 32'h300;
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_sel_i   = 4'h3;
        mem_addr_i  = 32'h200;
        mem_wdata_i = 32'h12345678;
        tick();
        n_checks++; if (bus_we_o !== 1'b1 || bus_sel_o !== 4'h3) begin n_fail++; $display("FAIL simul_mem_first: got we %b sel %h want 1 3", bus_we_o, bus_sel_o); end
        n_checks++; if (bus_addr_o !== 32'h200 || bus_wdata_o !== 32'h12345678) begin n_fail++; $display("FAIL simul_mem_bus: got %h/%h want 200/12345678", bus_addr_o, bus_wdata_o); end
        mem_addr_i  = 32'hBAD;
        mem_wdata_i = 32'h0;
        mem_sel_i   = 4'hC;
        tick();
        n_checks++; if (bus_addr_o !== 32'h200 || bus_wdata_o !== 32'h12345678 || bus_sel_o !== 4'h3) begin n_fail++; $display("FAIL simul_stable: got %h/%h/%h want 200/12345678/3", bus_addr_o, bus_wdata_o, bus_sel_o); end
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hFFFFFFFF;
        tick();
        n_checks++; if (mem_ack_o !== 1'b1 || if_ack_o !== 1'b0) begin n_fail++; $display("FAIL simul_mem_ack: got mem %b if %b want 1 0", mem_ack_o, if_ack_o); end
        n_checks++; if (mem_rdata_o !== 32'h0) begin n_fail++; $display("FAIL simul_write_rdata: got %h want 0", mem_rdata_o); end
        mem_req_i = 1'b0;
        bus_ack_i = 1'b0;
        tick();
        n_checks++; if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h300 || bus_sel_o !== 4'hF || bus_we_o !== 1'b0) begin n_fail++; $display("FAIL simul_if_next: got req %b addr %h sel %h we %b want 1 300 f 0", bus_req_o, bus_addr_o, bus_sel_o, bus_we_o); end
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hA5A5A5A5;
        tick();
        n_checks++; if (if_ack_o !== 1'b1 || if_rdata_o !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL simul_if_data: got ack %b data %h want 1 a5a5a5a5", if_ack_o, if_rdata_o); end
        if_req_i  = 1'b0;
        bus_ack_i = 1'b0;
        tick();
    endtask

    // MEM requests continuously; IF presents its request on each arbitrating
    // cycle. Four MEM wins, then IF is forced through, then the count restarts.
    task automatic test_starvation();
        logic [31:0] want_addr;
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'hF;
        mem_addr_i = 32'h400;
        if_addr_i  = 32'h500;
        for (int k = 0; k <= int'(STARVE_LIMIT); k++) begin
            if_req_i = 1'b1;
            tick();
            want_addr = (k < int'(STARVE_LIMIT)) ? 32'h400 : 32'h500;
            n_checks++; if (bus_req_o !== 1'b1 || bus_addr_o !== want_addr) begin n_fail++; $display("FAIL starve_grant%0d: got req %b addr %h want 1 %h", k, bus_req_o, bus_addr_o, want_addr); end
            if_req_i    = 1'b0;
            bus_ack_i   = 1'b1;
            bus_rdata_i = 32'(k);
            tick();
            bus_ack_i = 1'b0;
            tick();
            if (k == int'(STARVE_LIMIT)) begin
                // MEM was not the acked port, so it wins the edge right after IF's ack.
                n_checks++; if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h400) begin n_fail++; $display("FAIL starve_mem_after_if: got req %b addr %h want 1 400", bus_req_o, bus_addr_o); end
                bus_ack_i = 1'b1;
                tick();
                bus_ack_i = 1'b0;
                tick();
            end else begin
                n_checks++; if (bus_req_o !== 1'b0) begin n_fail++; $display("FAIL starve_gap%0d: got req %b want 0", k, bus_req_o); end
            end
        end
        if_req_i = 1'b1;
        tick();
        n_checks++; if (bus_addr_o !== 32'h400) begin n_fail++; $display("FAIL starve_cleared: got addr %h want 400", bus_addr_o); end
        if_req_i  = 1'b0;
        bus_ack_i = 1'b1;
        tick();
        mem_req_i = 1'b0;
        bus_ack_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_ack_on_timeout();
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'hF;
        mem_addr_i = 32'h600;
        tick();
        repeat (TIMEOUT - 1) tick();
        n_checks++; if (mem_ack_o !== 1'b0 || bus_req_o !== 1'b1) begin n_fail++; $display("FAIL ackto_waiting: got ack %b req %b want 0 1", mem_ack_o, bus_req_o); end
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hCAFEF00D;
        tick();
        n_checks++; if (mem_ack_o !== 1'b1 || err_o !== 1'b0) begin n_fail++; $display("FAIL ackto_done: got ack %b err %b want 1 0", mem_ack_o, err_o); end
        n_checks++; if (mem_rdata_o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ackto_data: got %h want cafef00d", mem_rdata_o); end
        mem_req_i = 1'b0;
        bus_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_addr_i = 32'h700;
        tick();
        for (int j = 1; j <= int'(TIMEOUT); j++) begin
            tick();
            if (j < int'(TIMEOUT)) begin
                n_checks++; if ({mem_ack_o, err_o, bus_req_o} !== 3'b001) begin n_fail++; $display("FAIL timeout_wait%0d: got ack/err/req %b want 001", j, {mem_ack_o, err_o, bus_req_o}); end
            end
        end
        n_checks++; if (mem_ack_o !== 1'b1 || err_o !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse: got ack %b err %b want 1 1", mem_ack_o, err_o); end
        n_checks++; if (mem_rdata_o !== 32'h0 || bus_req_o !== 1'b0) begin n_fail++; $display("FAIL timeout_data: got data %h req %b want 0 0", mem_rdata_o, bus_req_o); end
        mem_req_i   = 1'b0;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h5555AAAA;
        tick();
        n_checks++; if ({mem_ack_o, err_o, bus_req_o} !== 3'b000 || mem_rdata_o !== 32'h0) begin n_fail++; $display("FAIL timeout_late_ack: got ack/err/req %b data %h want 000 0", {mem_ack_o, err_o, bus_req_o}, mem_rdata_o); end
        bus_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit saw_ack;
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_sel_i   = 4'hF;
        mem_addr_i  = 32'h800;
        mem_wdata_i = 32'h99;
        tick();
        n_checks++; if (bus_req_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_grant: got req %b want 1", bus_req_o); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if ({bus_req_o, bus_we_o, mem_ack_o, err_o} !== 4'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got %b want 0000", {bus_req_o, bus_we_o, mem_ack_o, err_o}); end
        n_checks++; if (bus_sel_o !== 4'h0 || bus_addr_o !== 32'h0 || bus_wdata_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_bus: got %h/%h/%h want 0", bus_sel_o, bus_addr_o, bus_wdata_o); end
        mem_req_i = 1'b0;
        tick();
        rst = 1'b0;
        saw_ack = 1'b0;
        bus_ack_i = 1'b1;
        repeat (3) begin
            tick();
            if (mem_ack_o === 1'b1 || bus_req_o === 1'b1) saw_ack = 1'b1;
        end
        n_checks++; if (saw_ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_ack: got activity %b want 0", saw_ack); end
        bus_ack_i = 1'b0;
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic test_random();
        int ack_pct;
        int shown;
        logic stall_want;
        shown = 0;
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            if_req_i    = 1'($urandom % 2);
            if_addr_i   = 32'($urandom);
            mem_req_i   = 1'($urandom % 2);
            mem_we_i    = 1'($urandom % 2);
            mem_sel_i   = 4'($urandom);
            mem_addr_i  = 32'($urandom);
            mem_wdata_i = 32'($urandom);
            ack_pct     = ((i / 500) % 2 == 0) ? 45 : 3;
            bus_ack_i   = (int'($urandom % 100) < ack_pct);
            bus_rdata_i = 32'($urandom);
            #1;
            stall_want = (mem_req_i & ~m_mem_ack) | (if_req_i & ~m_if_ack);
            n_checks++; if (stallreq_o !== stall_want) begin n_fail++; if (shown++ < 20) $display("FAIL rand_stall@%0d: got %b want %b", i, stallreq_o, stall_want); end
            model_step();
            tick();
            n_checks++; if ({if_ack_o, mem_ack_o, err_o} !== {m_if_ack, m_mem_ack, m_err}) begin n_fail++; if (shown++ < 20) $display("FAIL rand_acks@%0d: got %b want %b", i, {if_ack_o, mem_ack_o, err_o}, {m_if_ack, m_mem_ack, m_err}); end
            n_checks++; if ({bus_req_o, bus_we_o, bus_sel_o} !== {m_bus_req, m_we, m_sel}) begin n_fail++; if (shown++ < 20) $display("FAIL rand_bus_ctrl@%0d: got %b want %b", i, {bus_req_o, bus_we_o, bus_sel_o}, {m_bus_req, m_we, m_sel}); end
            n_checks++; if (bus_addr_o !== m_addr || bus_wdata_o !== m_wdata) begin n_fail++; if (shown++ < 20) $display("FAIL rand_bus_data@%0d: got %h/%h want %h/%h", i, bus_addr_o, bus_wdata_o, m_addr, m_wdata); end
            n_checks++; if (if_rdata_o !== m_if_rd || mem_rdata_o !== m_mem_rd) begin n_fail++; if (shown++ < 20) $display("FAIL rand_rdata@%0d: got %h/%h want %h/%h", i, if_rdata_o, mem_rdata_o, m_if_rd, m_mem_rd); end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_if_read();
        test_back_to_back();
        test_simultaneous();
        test_starvation();
        test_ack_on_timeout();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
